analog_stick_dpad: RTL

Multi-stick analog-to-D-pad converter with per-stick centre calibration, hysteresis thresholds, sample-count debounce and an optional 4-way restriction. It sits between the Pocket controller interface, which delivers unsigned 8-bit axis bytes (0x00 = up/left, 0xFF = down/right), and the core's input mapping. Its registered D-pad bits are ORed with the digital D-pad downstream.

---
 rtl/analog_pad_pkg.sv | 14 +
 rtl/analog_axis_filter.sv | 84 ++++++++
 rtl/analog_stick_dpad.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/analog_pad_pkg.sv
// rtl/analog_pad_pkg.sv - shared types and helpers for the analog stick D-pad converter
package analog_pad_pkg;

  localparam int PAD_AXIS_W = 8;

  typedef enum logic [1:0] {NEG = 2'd0, NONE = 2'd1, POS = 2'd2} axis_dir_e;
  typedef enum logic {CAL = 1'b0, RUN = 1'b1} stick_state_e;

  // Magnitude of a signed offset; -2^AXIS_W maps to 2^AXIS_W, which still fits unsigned.
  function automatic logic [PAD_AXIS_W:0] abs_offset(input logic signed [PAD_AXIS_W:0] d);
    return d[PAD_AXIS_W] ? -d : d;
  endfunction

endpackage

// File: rtl/analog_axis_filter.sv
// rtl/analog_axis_filter.sv - per-axis centre offset, hysteresis and sample-count debounce
module analog_axis_filter
  import analog_pad_pkg::*;
#(
  parameter int                AXIS_W     = 8,
  parameter logic [AXIS_W-1:0] ENTER_TH   = 8'h30,
  parameter logic [AXIS_W-1:0] EXIT_TH    = 8'h20,
  parameter int                FILTER_CNT = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic              clear,
  input  logic [AXIS_W-1:0] sample,
  input  logic [AXIS_W-1:0] centre,
  output axis_dir_e         dir,
  output logic [AXIS_W:0]   mag
);

  localparam int CNT_W = $clog2(FILTER_CNT + 1);
  localparam logic signed [AXIS_W:0] ENTER_P = $signed({1'b0, ENTER_TH});
  localparam logic signed [AXIS_W:0] ENTER_N = -ENTER_P;
  localparam logic signed [AXIS_W:0] EXIT_P  = $signed({1'b0, EXIT_TH});
  localparam logic signed [AXIS_W:0] EXIT_N  = -EXIT_P;

  logic signed [AXIS_W:0] d;
  axis_dir_e              dir_q, prev_q, cand;
  logic [CNT_W-1:0]       cnt_q, cnt_inc;
  logic [AXIS_W:0]        mag_q;

  assign d = $signed({1'b0, sample}) - $signed({1'b0, centre});

  // Hysteresis is referenced to the debounced state, so release needs the narrower window.
  always_comb begin
    cand = dir_q;
    case (dir_q)
      NONE: begin
        if (d <= ENTER_N)      cand = NEG;
        else if (d >= ENTER_P) cand = POS;
      end
      NEG: begin
        if (d >= ENTER_P)      cand = POS;
        else if (d > EXIT_N)   cand = NONE;
      end
      POS: begin
        if (d <= ENTER_N)      cand = NEG;
        else if (d < EXIT_P)   cand = NONE;
      end
      default: cand = NONE;
    endcase
  end

  // A changed candidate restarts the run with this strobe as its first sample.
  assign cnt_inc = (cand != prev_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_q  <= NONE;
      prev_q <= NONE;
      cnt_q  <= '0;
      mag_q  <= '0;
    end else if (clear) begin
      dir_q  <= NONE;
      prev_q <= NONE;
      cnt_q  <= '0;
      mag_q  <= '0;
    end else if (sample_en) begin
      mag_q  <= abs_offset(d);
      prev_q <= cand;
      if (cand == dir_q) begin
        cnt_q <= '0;
      end else if (cnt_inc >= CNT_W'(FILTER_CNT)) begin
        dir_q <= cand;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign dir = dir_q;
  assign mag = mag_q;

endmodule

// File: rtl/analog_stick_dpad.sv
// rtl/analog_stick_dpad.sv - multi-stick analog to D-pad converter with calibration and 4-way mode
module analog_stick_dpad
  import analog_pad_pkg::*;
#(
  parameter int                NUM_STICKS = 2,
  parameter int                AXIS_W     = 8,
  parameter logic [AXIS_W-1:0] CENTER_DEF = 8'h80,
  parameter logic [AXIS_W-1:0] ENTER_TH   = 8'h30,
  parameter logic [AXIS_W-1:0] EXIT_TH    = 8'h20,
  parameter int                FILTER_CNT = 4,
  parameter int                CAL_LOG2   = 4,
  parameter logic [AXIS_W-1:0] CAL_LIMIT  = 8'h20
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [3:0]                   pad_type,
  input  logic                         sample_stb,
  input  logic [NUM_STICKS*AXIS_W-1:0] joy_x,
  input  logic [NUM_STICKS*AXIS_W-1:0] joy_y,
  input  logic                         mode_4way,
  input  logic                         recal,
  output logic                         cal_done,
  output logic                         joy_up,
  output logic                         joy_down,
  output logic                         joy_left,
  output logic                         joy_right
);

  localparam int ACC_W = AXIS_W + CAL_LOG2;

  logic [NUM_STICKS-1:0] stick_run;
  logic [NUM_STICKS-1:0] st_up, st_down, st_left, st_right;
  logic                  pad_active;

  // A centre too far from nominal means the stick was deflected during calibration.
  function automatic logic [AXIS_W-1:0] pick_centre(input logic [AXIS_W-1:0] avg);
    logic signed [AXIS_W:0] diff;
    diff = $signed({1'b0, avg}) - $signed({1'b0, CENTER_DEF});
    return (abs_offset(diff) > {1'b0, CAL_LIMIT}) ? CENTER_DEF : avg;
  endfunction

  for (genvar s = 0; s < NUM_STICKS; s++) begin : g_stick
    stick_state_e        state_q, state_d;
    logic [CAL_LOG2-1:0] cal_cnt_q;
    logic [ACC_W-1:0]    acc_x_q, acc_y_q, sum_x, sum_y;
    logic [AXIS_W-1:0]   cen_x_q, cen_y_q, x, y;
    logic                cal_last, run_en, keep_h, keep_v;
    axis_dir_e           dir_x, dir_y;
    logic [AXIS_W:0]     mag_x, mag_y;

    assign x        = joy_x[s*AXIS_W +: AXIS_W];
    assign y        = joy_y[s*AXIS_W +: AXIS_W];
    assign sum_x    = acc_x_q + ACC_W'(x);
    assign sum_y    = acc_y_q + ACC_W'(y);
    assign cal_last = (cal_cnt_q == '1);
    assign run_en   = sample_stb && !recal && (state_q == RUN);

    always_comb begin
      state_d = state_q;
      if (recal)
        state_d = CAL;
      else if (state_q == CAL && sample_stb && cal_last)
        state_d = RUN;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= CAL;
        cal_cnt_q <= '0;
        acc_x_q   <= '0;
        acc_y_q   <= '0;
        cen_x_q   <= CENTER_DEF;
        cen_y_q   <= CENTER_DEF;
      end else begin
        state_q <= state_d;
        if (recal) begin
          cal_cnt_q <= '0;
          acc_x_q   <= '0;
          acc_y_q   <= '0;
        end else if (state_q == CAL && sample_stb) begin
          if (cal_last) begin
            cen_x_q   <= pick_centre(sum_x[ACC_W-1:CAL_LOG2]);
            cen_y_q   <= pick_centre(sum_y[ACC_W-1:CAL_LOG2]);
            cal_cnt_q <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
          end else begin
            cal_cnt_q <= cal_cnt_q + 1'b1;
            acc_x_q   <= sum_x;
            acc_y_q   <= sum_y;
          end
        end
      end
    end

    analog_axis_filter #(
      .AXIS_W(AXIS_W), .ENTER_TH(ENTER_TH), .EXIT_TH(EXIT_TH), .FILTER_CNT(FILTER_CNT)
    ) u_x (
      .clk_sys(clk_sys), .reset_n(reset_n), .sample_en(run_en), .clear(recal),
      .sample(x), .centre(cen_x_q), .dir(dir_x), .mag(mag_x)
    );

    analog_axis_filter #(
      .AXIS_W(AXIS_W), .ENTER_TH(ENTER_TH), .EXIT_TH(EXIT_TH), .FILTER_CNT(FILTER_CNT)
    ) u_y (
      .clk_sys(clk_sys), .reset_n(reset_n), .sample_en(run_en), .clear(recal),
      .sample(y), .centre(cen_y_q), .dir(dir_y), .mag(mag_y)
    );

    // Diagonal in 4-way mode keeps the dominant axis; horizontal wins ties.
    always_comb begin
      keep_h = 1'b1;
      keep_v = 1'b1;
      if (mode_4way && dir_x != NONE && dir_y != NONE) begin
        keep_h = (mag_x >= mag_y);
        keep_v = !keep_h;
      end
    end

    assign stick_run[s] = (state_q == RUN);
    assign st_left[s]   = stick_run[s] && keep_h && (dir_x == NEG);
    assign st_right[s]  = stick_run[s] && keep_h && (dir_x == POS);
    assign st_up[s]     = stick_run[s] && keep_v && (dir_y == NEG);
    assign st_down[s]   = stick_run[s] && keep_v && (dir_y == POS);
  end

  assign cal_done   = &stick_run;
  assign pad_active = (pad_type == 4'h3);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_up    <= 1'b0;
      joy_down  <= 1'b0;
      joy_left  <= 1'b0;
      joy_right <= 1'b0;
    end else begin
      joy_up    <= pad_active && (|st_up);
      joy_down  <= pad_active && (|st_down);
      joy_left  <= pad_active && (|st_left);
      joy_right <= pad_active && (|st_right);
    end
  end

endmodule
